jk_excite_driver: RTL and testbench

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

---
 rtl/jk_drv_pkg.sv | 17 +
 rtl/jk_excite.sv | 21 ++
 rtl/jk_excite_driver.sv | 94 +++++++++
 tb/tb_jk_excite_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK flip-flop excitation driver.
// Holds the controller state encoding and the single-bit JK excitation rule.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  // Returns {J, K}. Moves q toward t and never asserts both.
  function automatic logic [1:0] jk_bit(input logic q, input logic t);
    return {~q & t, q & ~t};
  endfunction

endpackage

// File: rtl/jk_excite.sv
// WIDTH-wide combinational JK excitation.
// Produces the J/K values that move q_fb toward target.
module jk_excite #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K
);
  import jk_drv_pkg::*;

  always_comb begin
    J = '0;
    K = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {J[i], K[i]} = jk_bit(q_fb[i], target[i]);
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a bank of J-priority JK flip-flops toward a captured target.
// Each attempt is DRIVE/SETTLE/CHECK, with bounded retries on mismatch.
module jk_excite_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic             ack,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import jk_drv_pkg::*;

  localparam int unsigned CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(MAX_RETRY);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] target_r;
  logic [CNT_W-1:0] retry_cnt;
  logic             done_r;
  logic             err_r;
  logic             match;
  logic             retry_left;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;

  assign match      = (q_fb == target_r);
  assign retry_left = (retry_cnt != RETRY_LAST);

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .target (target_r),
    .q_fb   (q_fb),
    .J      (j_drv),
    .K      (k_drv)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      target_r  <= '0;
      retry_cnt <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state == CHECK) && match;
      err_r  <= (state == CHECK) && !match && !retry_left;
      if ((state == IDLE) && req) begin
        target_r  <= target;
        retry_cnt <= '0;
      end else if ((state == CHECK) && !match && retry_left) begin
        retry_cnt <= retry_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = DRIVE;
      DRIVE:   state_nx = SETTLE;
      SETTLE:  state_nx = CHECK;
      CHECK: begin
        if (match || !retry_left) state_nx = IDLE;
        else                      state_nx = DRIVE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ack keys off the retry count so retry DRIVE cycles stay silent.
  always_comb begin
    J    = '0;
    K    = '0;
    ack  = 1'b0;
    busy = (state != IDLE);
    done = done_r;
    err  = err_r;
    if (state == DRIVE) begin
      J   = j_drv;
      K   = k_drv;
      ack = (retry_cnt == '0);
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Self-checking bench for jk_excite_driver with a J-priority JK flip-flop bank model.
module tb_jk_excite_driver;

  localparam int R = 2;

  logic       CLK, RST, req;
  logic [7:0] target, q_fb, J, K;
  logic       ack, busy, done, err;

  logic [7:0] q_bank, stuck, preload_val;
  logic       preload_en;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] tgt;
    logic [7:0] stk;
    logic [7:0] ej;
    logic [7:0] ek;
    logic [7:0] eq;
    int         ecyc;
    bit         eok;
  } vec_t;

  vec_t tbl[7];

  int         a_ack_cnt, a_ack_cyc, a_done_cyc, a_err_cyc, a_trace_bad, a_overlap;
  logic [7:0] a_j1, a_k1, a_q_end;

  jk_excite_driver #(.WIDTH(8), .MAX_RETRY(R)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .req    (req),
    .target (target),
    .q_fb   (q_fb),
    .ack    (ack),
    .J      (J),
    .K      (K),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flip-flop bank: J wins over K; stuck bits always read 0.
  always @(posedge CLK) begin
    if (preload_en) q_bank <= preload_val & ~stuck;
    else begin
      for (int i = 0; i < 8; i++) begin
        if (stuck[i])  q_bank[i] <= 1'b0;
        else if (J[i]) q_bank[i] <= 1'b1;
        else if (K[i]) q_bank[i] <= 1'b0;
      end
    end
  end
  assign q_fb = q_bank;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Outcome of one transaction, from the rules: every drive moves all free bits to target.
  function automatic vec_t model(input logic [7:0] q0, input logic [7:0] tgt, input logic [7:0] stk);
    vec_t v;
    logic [7:0] qa;
    qa     = q0 & ~stk;
    v.q0   = q0;
    v.tgt  = tgt;
    v.stk  = stk;
    v.eok  = ((tgt & stk) == 8'h00);
    v.ecyc = v.eok ? 4 : 3 * (R + 1) + 1;
    v.ej   = tgt & ~qa;
    v.ek   = qa & ~tgt;
    v.eq   = tgt & ~stk;
    return v;
  endfunction

  task automatic prep(input logic [7:0] q0, input logic [7:0] stk);
    @(posedge CLK); #1;
    stuck       = stk;
    preload_val = q0;
    preload_en  = 1'b1;
    @(posedge CLK); #1;
    preload_en  = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int hold_n, input logic [7:0] hold_tgt, input bit skip_prep);
    logic [7:0] qa, qs, qp, ej, ek;
    bit drv;
    qa = v.q0 & ~v.stk;
    qs = v.tgt & ~v.stk;
    a_ack_cnt = 0; a_ack_cyc = 0; a_done_cyc = 0; a_err_cyc = 0;
    a_trace_bad = 0; a_overlap = 0; a_j1 = '0; a_k1 = '0; a_q_end = '0;
    if (!skip_prep) prep(v.q0, v.stk);
    req    = 1'b1;
    target = v.tgt;
    for (int c = 1; c <= v.ecyc + 2; c++) begin
      @(posedge CLK); #1;
      drv = ((c - 1) % 3 == 0) && (c < v.ecyc);
      qp  = (c == 1) ? qa : qs;
      ej  = drv ? (v.tgt & ~qp) : 8'h00;
      ek  = drv ? (qp & ~v.tgt) : 8'h00;
      if (c == 1) begin a_j1 = J; a_k1 = K; end
      if (ack) begin a_ack_cnt++; a_ack_cyc = c; end
      if (done && a_done_cyc == 0) a_done_cyc = c;
      if (err && a_err_cyc == 0) a_err_cyc = c;
      if ((J & K) != 8'h00 || (done && err)) a_overlap++;
      if (c == v.ecyc) a_q_end = q_fb;
      if (J !== ej || K !== ek || busy !== (c < v.ecyc) ||
          done !== (v.eok && c == v.ecyc) || err !== (!v.eok && c == v.ecyc))
        a_trace_bad++;
      if (c <= hold_n) begin req = 1'b1; target = hold_tgt; end
      else req = 1'b0;
    end
  endtask

  task automatic verify(input string nm, input vec_t e);
    chk({nm, "_ack_cnt"}, a_ack_cnt, 1);
    chk({nm, "_ack_cyc"}, a_ack_cyc, 1);
    chk({nm, "_J1"}, {24'h0, a_j1}, {24'h0, e.ej});
    chk({nm, "_K1"}, {24'h0, a_k1}, {24'h0, e.ek});
    if (e.eok) begin
      chk({nm, "_done_cyc"}, a_done_cyc, e.ecyc);
      chk({nm, "_err_cyc"}, a_err_cyc, 0);
    end else begin
      chk({nm, "_err_cyc"}, a_err_cyc, e.ecyc);
      chk({nm, "_done_cyc"}, a_done_cyc, 0);
    end
    chk({nm, "_q_end"}, {24'h0, a_q_end}, {24'h0, e.eq});
    chk({nm, "_trace"}, a_trace_bad, 0);
    chk({nm, "_jk_overlap"}, a_overlap, 0);
  endtask

  initial begin : main
    vec_t       v;
    logic [7:0] s;
    int         quiet, ack_mask, done_mask;
    logic [7:0] k5;

    tbl[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 4, 1'b1};
    tbl[1] = '{8'hF0, 8'h0F, 8'h00, 8'h0F, 8'hF0, 8'h0F, 4, 1'b1};
    tbl[2] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 10, 1'b0};
    tbl[3] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h3C, 4, 1'b1};
    tbl[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 4, 1'b1};
    tbl[5] = '{8'h81, 8'h7E, 8'h80, 8'h7E, 8'h01, 8'h7E, 4, 1'b1};
    tbl[6] = '{8'hC3, 8'h96, 8'h04, 8'h14, 8'h41, 8'h92, 10, 1'b0};

    RST = 1'b0; req = 1'b0; target = '0;
    stuck = '0; preload_val = '0; preload_en = 1'b1;
    #1 RST = 1'b1;
    #1 chk("reset_out", {12'h0, ack, busy, done, err, J, K}, 32'h0);
    #10 RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], 0, 8'h00, 1'b0);
      verify($sformatf("tbl%0d", i), tbl[i]);
    end

    // Same-as-current target, with a competing req held through DRIVE/SETTLE/CHECK.
    v = model(8'h3C, 8'h3C, 8'h00);
    run_txn(v, 3, 8'h55, 1'b0);
    verify("hold_busy", v);

    // Back-to-back: req in the done cycle is accepted.
    prep(8'h00, 8'h00);
    req = 1'b1; target = 8'h0F;
    ack_mask = 0; done_mask = 0; k5 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (ack)  ack_mask  |= (1 << c);
      if (done) done_mask |= (1 << c);
      if (c == 5) k5 = K;
      if (c == 4) begin req = 1'b1; target = 8'hF0; end
      else req = 1'b0;
    end
    chk("b2b_ack_cycles", ack_mask, (1 << 1) | (1 << 5));
    chk("b2b_done_cycles", done_mask, (1 << 4) | (1 << 8));
    chk("b2b_K_second", {24'h0, k5}, 32'h0F);

    // Reset pulsed mid-cycle while in DRIVE.
    prep(8'h00, 8'h00);
    req = 1'b1; target = 8'hA5;
    @(posedge CLK); #1;
    req = 1'b0;
    chk("rst_drive_pre_ack", {31'h0, ack}, 32'h1);
    #2 RST = 1'b1;
    #1 chk("rst_drive_out", {12'h0, ack, busy, done, err, J, K}, 32'h0);
    #3 RST = 1'b0;
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (done || err || busy || ack) quiet++;
    end
    chk("rst_drive_quiet", quiet, 0);

    // Reset during SETTLE, then a new req right after deassertion.
    prep(8'h00, 8'h00);
    req = 1'b1; target = 8'h18;
    @(posedge CLK); #1;
    req = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b1;
    #1 chk("rst_settle_out", {12'h0, ack, busy, done, err, J, K}, 32'h0);
    #3 RST = 1'b0;
    v = model(8'h18, 8'h81, 8'h00);
    run_txn(v, 0, 8'h00, 1'b1);
    verify("rst_settle_new", v);

    for (int i = 0; i < 24; i++) begin
      s = 8'h00;
      if ($urandom_range(0, 2) == 0) begin
        s = 8'h01;
        s = s << $urandom_range(0, 7);
      end
      v = model(8'($urandom), 8'($urandom), s);
      run_txn(v, 0, 8'h00, 1'b0);
      verify($sformatf("rnd%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
